bram_uart_unpacker: RTL and testbench

//   Read-back path from CPU BRAM to the UART transmitter, running in the CPU clock domain.
//   On a start pulse it reads a run of 16-bit BRAM words and splits each word into bytes,

---
 rtl/bram_uart_unpacker_if.sv | 29 ++
 rtl/bram_uart_unpacker.sv | 127 ++++++++++++
 tb/tb_bram_uart_unpacker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bram_uart_unpacker_if.sv
// Bus bundle between the BRAM-to-UART unpacker and its surroundings:
// start/command, BRAM read port, UART TX valid/ready and status.
interface bram_uart_unpacker_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_start_addr;
  logic [ADDR_WIDTH:0]   i_byte_count;
  logic [ADDR_WIDTH-1:0] o_addr_bram;
  logic                  o_rd_en_bram;
  logic [15:0]           i_data_bram;
  logic [7:0]            o_data_uart;
  logic                  o_valid_uart;
  logic                  i_ready_uart;
  logic                  o_busy;
  logic                  o_done;

  // The unpacker itself
  modport master (
    input  i_start, i_start_addr, i_byte_count, i_data_bram, i_ready_uart,
    output o_addr_bram, o_rd_en_bram, o_data_uart, o_valid_uart, o_busy, o_done
  );

  // Command source, BRAM and UART TX
  modport slave (
    output i_start, i_start_addr, i_byte_count, i_data_bram, i_ready_uart,
    input  o_addr_bram, o_rd_en_bram, o_data_uart, o_valid_uart, o_busy, o_done
  );
endinterface

// File: rtl/bram_uart_unpacker.sv
// Reads a run of 16-bit BRAM words and streams them to the UART TX as bytes,
// high byte first; an odd byte count drops the low byte of the final word.
module bram_uart_unpacker #(
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  bram_uart_unpacker_if.master  bus
);

  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, SEND_HI, SEND_LO, DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_W-1:0]      remaining;
  logic [15:0]           word_q;
  logic [LAT_W-1:0]      lat_cnt;

  logic [ADDR_WIDTH-1:0] addr_bram;
  logic                  rd_en_bram;
  logic [7:0]            data_uart;
  logic                  valid_uart;
  logic                  busy;
  logic                  done;

  logic lat_last;
  logic last_byte;
  assign lat_last  = (lat_cnt == LAT_W'(RD_LATENCY - 1));
  assign last_byte = (remaining == CNT_W'(1));

  // All outputs are registered alongside the state so they change only on
  // state transitions; valid/data therefore cannot glitch while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      addr_bram  <= '0;
      rd_en_bram <= 1'b0;
      data_uart  <= '0;
      valid_uart <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      rd_en_bram <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            addr      <= bus.i_start_addr;
            remaining <= bus.i_byte_count;
            busy      <= 1'b1;
            if (bus.i_byte_count == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rd_en_bram <= 1'b1;
              addr_bram  <= bus.i_start_addr;
              state      <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          lat_cnt <= '0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_last) begin
            word_q     <= bus.i_data_bram;
            data_uart  <= bus.i_data_bram[15:8];
            valid_uart <= 1'b1;
            state      <= SEND_HI;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        SEND_HI: begin
          if (bus.i_ready_uart) begin
            remaining <= remaining - CNT_W'(1);
            if (last_byte) begin
              valid_uart <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              data_uart <= word_q[7:0];
              state     <= SEND_LO;
            end
          end
        end
        SEND_LO: begin
          if (bus.i_ready_uart) begin
            remaining  <= remaining - CNT_W'(1);
            valid_uart <= 1'b0;
            if (last_byte) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // Next word is fetched only after both bytes have left; no prefetch.
              addr       <= addr + ADDR_WIDTH'(1);
              addr_bram  <= addr + ADDR_WIDTH'(1);
              rd_en_bram <= 1'b1;
              state      <= RD_REQ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_addr_bram  = addr_bram;
  assign bus.o_rd_en_bram = rd_en_bram;
  assign bus.o_data_uart  = data_uart;
  assign bus.o_valid_uart = valid_uart;
  assign bus.o_busy       = busy;
  assign bus.o_done       = done;

endmodule

// File: tb/tb_bram_uart_unpacker.sv
// Directed and randomized bench for bram_uart_unpacker: BRAM model, random
// UART back-pressure, and a byte-stream reference derived from the word array.
module tb_bram_uart_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_uart_unpacker_if #(.ADDR_WIDTH(8)) bus ();

  bram_uart_unpacker #(.ADDR_WIDTH(8), .RD_LATENCY(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [15:0] mem [256];
  always @(posedge clk) if (bus.o_rd_en_bram) bus.i_data_bram <= mem[bus.o_addr_bram];

  // Ready driver: 0 = always ready, 1 = random, 2 = held low, 3 = manual
  int rmode = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: bus.i_ready_uart = 1'b1;
      1: bus.i_ready_uart = 1'($urandom_range(0, 1));
      2: bus.i_ready_uart = 1'b0;
      default: ;
    endcase
  end

  // Observed traffic, sampled on the falling edge
  logic [7:0] got_q[$];
  logic [7:0] rd_q[$];
  int done_cnt, busy_cyc, stall_viol, prefetch_viol;
  logic pv, pr;
  logic [7:0] pd;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (bus.o_rd_en_bram) begin
        rd_q.push_back(bus.o_addr_bram);
        if (bus.o_valid_uart) prefetch_viol++;
      end
      if (bus.o_valid_uart && bus.i_ready_uart) got_q.push_back(bus.o_data_uart);
      if (bus.o_done) done_cnt++;
      if (bus.o_busy) busy_cyc++;
      if (pv && !pr && !(bus.o_valid_uart && bus.o_data_uart === pd)) stall_viol++;
      pv = bus.o_valid_uart;
      pr = bus.i_ready_uart;
      pd = bus.o_data_uart;
    end
  end

  int ncmp = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    rd_q.delete();
    done_cnt = 0; busy_cyc = 0; stall_viol = 0; prefetch_viol = 0;
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [8:0] n,
                     input int mode, input bit hold, input bit extra);
    logic [7:0] exp_q[$];
    logic [7:0] exp_rd[$];
    logic [15:0] w;
    int nb, words, exp_busy;
    nb = int'(n);
    words = (nb + 1) / 2;
    for (int i = 0; i < nb; i++) begin
      w = mem[8'(int'(a) + i / 2)];
      exp_q.push_back((i % 2 == 0) ? w[15:8] : w[7:0]);
    end
    for (int k = 0; k < words; k++) exp_rd.push_back(8'(int'(a) + k));
    exp_busy = words * 4 - (nb % 2) + 1;

    rmode = hold ? 2 : mode;
    @(posedge clk); #2;
    clear_obs();
    bus.i_start = 1'b1; bus.i_start_addr = a; bus.i_byte_count = n;
    @(posedge clk); #2;
    bus.i_start = 1'b0;
    bus.i_start_addr = 8'($urandom); bus.i_byte_count = 9'($urandom);
    if (extra) begin
      @(posedge clk); #2;
      bus.i_start = 1'b1;
      @(posedge clk); #2;
      bus.i_start = 1'b0;
    end
    if (hold) begin
      repeat (12) @(posedge clk);
      #2 rmode = mode;
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk);
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (8) @(negedge clk);

    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_read_count"}, 32'(rd_q.size()), 32'(exp_rd.size()));
    for (int k = 0; k < exp_rd.size() && k < rd_q.size(); k++)
      check($sformatf("%s_rdaddr%0d", tag, k), 32'(rd_q[k]), 32'(exp_rd[k]));
    check({tag, "_stall_stable"}, 32'(stall_viol), 32'd0);
    check({tag, "_no_prefetch"}, 32'(prefetch_viol), 32'd0);
    if (mode == 0 && !hold) check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    check({tag, "_idle_valid"}, 32'(bus.o_valid_uart), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[1] = 16'hA1B2; mem[2] = 16'hC3D4;
    mem[5] = 16'h1234; mem[6] = 16'h5678;
    bus.i_start = 1'b0; bus.i_start_addr = '0; bus.i_byte_count = '0;
    bus.i_ready_uart = 1'b0;
    clear_obs();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.o_valid_uart), 32'd0);
    check("rst_rd_en", 32'(bus.o_rd_en_bram), 32'd0);
    check("rst_busy",  32'(bus.o_busy), 32'd0);
    check("rst_done",  32'(bus.o_done), 32'd0);
    check("rst_addr",  32'(bus.o_addr_bram), 32'd0);
    check("rst_data",  32'(bus.o_data_uart), 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    run("t1_basic",   8'h01, 9'd4, 0, 1'b0, 1'b0);
    run("t2_odd",     8'h05, 9'd3, 0, 1'b0, 1'b1);
    run("t3_zero",    8'($urandom), 9'd0, 0, 1'b0, 1'b0);
    run("t4_stall",   8'($urandom), 9'd10, 1, 1'b1, 1'b0);
    run("t5_wrap",    8'hFF, 9'd4, 0, 1'b0, 1'b0);

    // Reset while the low byte of the first word is pending
    rmode = 3;
    @(posedge clk); #2;
    bus.i_ready_uart = 1'b0;
    clear_obs();
    bus.i_start = 1'b1; bus.i_start_addr = 8'h20; bus.i_byte_count = 9'd6;
    @(posedge clk); #2 bus.i_start = 1'b0;
    for (int i = 0; i < 50 && !bus.o_valid_uart; i++) @(negedge clk);
    check("t6_hi_valid", 32'(bus.o_valid_uart), 32'd1);
    @(posedge clk); #2 bus.i_ready_uart = 1'b1;
    @(posedge clk); #2 bus.i_ready_uart = 1'b0;
    @(negedge clk);
    check("t6_hi_sent", 32'(got_q.size()), 32'd1);
    check("t6_lo_valid", 32'(bus.o_valid_uart), 32'd1);
    check("t6_lo_data", 32'(bus.o_data_uart), 32'(mem[8'h20][7:0]));
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check("t6_rst_valid", 32'(bus.o_valid_uart), 32'd0);
    check("t6_rst_busy",  32'(bus.o_busy), 32'd0);
    check("t6_rst_done",  32'(bus.o_done), 32'd0);
    check("t6_rst_rd_en", 32'(bus.o_rd_en_bram), 32'd0);
    check("t6_rst_addr",  32'(bus.o_addr_bram), 32'd0);
    check("t6_rst_data",  32'(bus.o_data_uart), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_no_done", 32'(done_cnt), 32'd0);
    check("t6_no_bytes", 32'(got_q.size()), 32'd1);
    run("t6_after", 8'h20, 9'd6, 0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++)
      run($sformatf("rand%0d", r), 8'($urandom), 9'($urandom_range(1, 40)), 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
